// File: rtl/character_rom.sv
// 8x8 monochrome font ROM: one registered pixel per clock from {character, y, x}.
// Build option CHARACTER_ROM_CONTROL_BOX_EN draws codes 0x00-0x1F and 0x7F as a hollow box.
module character_rom (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic [6:0] character,
    output logic       dot
);

`ifdef CHARACTER_ROM_CONTROL_BOX_EN
    localparam logic [63:0] CTRL_GLYPH = 64'h7E42_4242_4242_7E00;
`else
    localparam logic [63:0] CTRL_GLYPH = 64'h0000_0000_0000_0000;
`endif

    // Row y occupies byte [63-8y -: 8]; its bit 7 is column 0.
    logic [63:0] glyph;
    logic        dot_d;
    logic        dot_q;

    always_comb begin
        glyph = CTRL_GLYPH;
        case (character)
            7'h20: glyph = 64'h0000_0000_0000_0000;
            7'h21: glyph = 64'h1818_1818_1800_1800;
            7'h22: glyph = 64'h6666_2400_0000_0000;
            7'h23: glyph = 64'h6C6C_FE6C_FE6C_6C00;
            7'h24: glyph = 64'h183E_603C_067C_1800;
            7'h25: glyph = 64'h6266_0C18_3066_4600;
            7'h26: glyph = 64'h386C_3876_DCCC_7600;
            7'h27: glyph = 64'h1818_3000_0000_0000;
            7'h28: glyph = 64'h0C18_3030_3018_0C00;
            7'h29: glyph = 64'h3018_0C0C_0C18_3000;
            7'h2A: glyph = 64'h0066_3CFE_3C66_0000;
            7'h2B: glyph = 64'h0018_187E_1818_0000;
            7'h2C: glyph = 64'h0000_0000_1818_3000;
            7'h2D: glyph = 64'h0000_007E_0000_0000;
            7'h2E: glyph = 64'h0000_0000_0018_1800;
            7'h2F: glyph = 64'h060C_1830_60C0_8000;
            7'h30: glyph = 64'h3C66_6E76_6666_3C00;
            7'h31: glyph = 64'h1838_1818_1818_7E00;
            7'h32: glyph = 64'h3C66_060C_3060_7E00;
            7'h33: glyph = 64'h3C66_061C_0666_3C00;
            7'h34: glyph = 64'h0C1C_3C6C_7E0C_0C00;
            7'h35: glyph = 64'h7E60_7C06_0666_3C00;
            7'h36: glyph = 64'h3C60_7C66_6666_3C00;
            7'h37: glyph = 64'h7E06_0C18_3030_3000;
            7'h38: glyph = 64'h3C66_663C_6666_3C00;
            7'h39: glyph = 64'h3C66_663E_060C_3800;
            7'h3A: glyph = 64'h0018_1800_0018_1800;
            7'h3B: glyph = 64'h0018_1800_1818_3000;
            7'h3C: glyph = 64'h0C18_3060_3018_0C00;
            7'h3D: glyph = 64'h0000_7E00_7E00_0000;
            7'h3E: glyph = 64'h3018_0C06_0C18_3000;
            7'h3F: glyph = 64'h3C66_060C_1800_1800;
            7'h40: glyph = 64'h3C66_6E6A_6E60_3C00;
            7'h41: glyph = 64'h183C_6666_7E66_6600;
            7'h42: glyph = 64'h7C66_667C_6666_7C00;
            7'h43: glyph = 64'h3C66_6060_6066_3C00;
            7'h44: glyph = 64'h786C_6666_666C_7800;
            7'h45: glyph = 64'h7E60_607C_6060_7E00;
            7'h46: glyph = 64'h7E60_607C_6060_6000;
            7'h47: glyph = 64'h3C66_606E_6666_3E00;
            7'h48: glyph = 64'h6666_667E_6666_6600;
            7'h49: glyph = 64'h7E18_1818_1818_7E00;
            7'h4A: glyph = 64'h3E0C_0C0C_0C6C_3800;
            7'h4B: glyph = 64'h666C_7870_786C_6600;
            7'h4C: glyph = 64'h6060_6060_6060_7E00;
            7'h4D: glyph = 64'hC6EE_FED6_C6C6_C600;
            7'h4E: glyph = 64'h6676_7E7E_6E66_6600;
            7'h4F: glyph = 64'h3C66_6666_6666_3C00;
            7'h50: glyph = 64'h7C66_667C_6060_6000;
            7'h51: glyph = 64'h3C66_6666_6A6C_3600;
            7'h52: glyph = 64'h7C66_667C_6C66_6600;
            7'h53: glyph = 64'h3C66_603C_0666_3C00;
            7'h54: glyph = 64'h7E18_1818_1818_1800;
            7'h55: glyph = 64'h6666_6666_6666_3C00;
            7'h56: glyph = 64'h6666_6666_663C_1800;
            7'h57: glyph = 64'hC6C6_C6D6_FEEE_C600;
            7'h58: glyph = 64'h6666_3C18_3C66_6600;
            7'h59: glyph = 64'h6666_663C_1818_1800;
            7'h5A: glyph = 64'h7E06_0C18_3060_7E00;
            7'h5B: glyph = 64'h3C30_3030_3030_3C00;
            7'h5C: glyph = 64'hC060_3018_0C06_0200;
            7'h5D: glyph = 64'h3C0C_0C0C_0C0C_3C00;
            7'h5E: glyph = 64'h183C_6600_0000_0000;
            7'h5F: glyph = 64'h0000_0000_0000_FE00;
            7'h60: glyph = 64'h3018_0C00_0000_0000;
            7'h61: glyph = 64'h0000_3C06_3E66_3E00;
            7'h62: glyph = 64'h6060_7C66_6666_7C00;
            7'h63: glyph = 64'h0000_3C66_6066_3C00;
            7'h64: glyph = 64'h0606_3E66_6666_3E00;
            7'h65: glyph = 64'h0000_3C66_7E60_3C00;
            7'h66: glyph = 64'h1C30_307C_3030_3000;
            7'h67: glyph = 64'h003E_6666_3E06_3C00;
            7'h68: glyph = 64'h6060_7C66_6666_6600;
            7'h69: glyph = 64'h1800_3818_1818_3C00;
            7'h6A: glyph = 64'h0C00_1C0C_0C6C_3800;
            7'h6B: glyph = 64'h6060_666C_786C_6600;
            7'h6C: glyph = 64'h3818_1818_1818_3C00;
            7'h6D: glyph = 64'h0000_6CFE_D6D6_C600;
            7'h6E: glyph = 64'h0000_7C66_6666_6600;
            7'h6F: glyph = 64'h0000_3C66_6666_3C00;
            7'h70: glyph = 64'h007C_6666_7C60_6000;
            7'h71: glyph = 64'h003E_6666_3E06_0600;
            7'h72: glyph = 64'h0000_7C66_6060_6000;
            7'h73: glyph = 64'h0000_3E60_3C06_7C00;
            7'h74: glyph = 64'h3030_7C30_3030_1C00;
            7'h75: glyph = 64'h0000_6666_6666_3E00;
            7'h76: glyph = 64'h0000_6666_663C_1800;
            7'h77: glyph = 64'h0000_C6D6_D6FE_6C00;
            7'h78: glyph = 64'h0000_663C_183C_6600;
            7'h79: glyph = 64'h0066_6666_3E06_3C00;
            7'h7A: glyph = 64'h0000_7E0C_1830_7E00;
            7'h7B: glyph = 64'h0E18_1870_1818_0E00;
            7'h7C: glyph = 64'h1818_1818_1818_1800;
            7'h7D: glyph = 64'h7018_180E_1818_7000;
            7'h7E: glyph = 64'h76DC_0000_0000_0000;
            default: glyph = CTRL_GLYPH;
        endcase
    end

    // Bit index 63 - (8y + x) picks row y, column x with column 0 at the byte MSB.
    assign dot_d = glyph[6'd63 - {y, x}];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dot_q <= 1'b0;
        end else begin
            dot_q <= dot_d;
        end
    end

    assign dot = dot_q;

endmodule

// File: tb/tb_character_rom.sv
// Self-checking bench for character_rom: directed scans plus random lookups against a glyph-rule model.
// Define CHARACTER_ROM_CONTROL_BOX_EN for both bench and RTL to check the box build.
module tb_character_rom;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] x = 3'd0;
    logic [2:0] y = 3'd0;
    logic [6:0] character = 7'h00;
    logic       dot;

    int vectors = 0;
    int miscompares = 0;

    // 'A' drawn as pixel art, row 0 first, column 0 leftmost.
    string a_art [8] = '{
        "...##...",
        "..####..",
        ".##..##.",
        ".##..##.",
        ".######.",
        ".##..##.",
        ".##..##.",
        "........"
    };

    character_rom dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .character (character),
        .dot       (dot)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d required finish", vectors);
        $fatal(1, "watchdog expired");
    end

    // Returns 1 when the glyph rules pin down the pixel; exp then holds its value.
    function automatic bit model(input logic [6:0] ch, input logic [2:0] xx, input logic [2:0] yy,
                                 output logic exp);
        int xi = int'(xx);
        int yi = int'(yy);
        exp = 1'b0;
        if (ch < 7'h20 || ch == 7'h7F) begin
`ifdef CHARACTER_ROM_CONTROL_BOX_EN
            exp = (yi <= 6 && xi >= 1 && xi <= 6 && (yi == 0 || yi == 6 || xi == 1 || xi == 6));
`endif
            return 1'b1;
        end
        if (ch == 7'h20) return 1'b1;
        if (ch == 7'h41) begin
            exp = (a_art[yi][xi] == "#");
            return 1'b1;
        end
        if (xi == 7 || yi == 7) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic exp);
        vectors++;
        assert (dot === exp) else begin
            miscompares++;
            $error("FAIL %s: dot=%b expected %b (ch=%h x=%0d y=%0d)", tag, dot, exp, character, x, y);
        end
    endtask

    // Drive one set of inputs, clock once, then compare whenever the model knows the answer.
    task automatic step(input logic [6:0] ch, input logic [2:0] xx, input logic [2:0] yy,
                        input logic rn, input string tag);
        logic exp;
        bit   known;
        character = ch;
        x = xx;
        y = yy;
        reset_n = rn;
        @(posedge clock);
        #1;
        if (!rn) begin
            known = 1'b1;
            exp = 1'b0;
        end else begin
            known = model(ch, xx, yy, exp);
        end
        if (known) check(tag, exp);
    endtask

    initial begin
        @(negedge clock);

        step(7'h41, 3'd1, 3'd0, 1'b0, "reset_edge0");
        step(7'h41, 3'd1, 3'd0, 1'b0, "reset_edge1");
        step(7'h41, 3'd3, 3'd0, 1'b1, "release_first_pixel");
        step(7'h41, 3'd1, 3'd0, 1'b1, "release_x1");

        // Full 'A' scan with a one-edge reset dropped into row 3.
        for (int yy = 0; yy < 8; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                if (yy == 3 && xx == 2) step(7'h41, 3'(xx), 3'(yy), 1'b0, "midscan_reset");
                step(7'h41, 3'(xx), 3'(yy), 1'b1, (yy == 4) ? "a_row4" : "a_scan");
            end
        end

        // Output must stay put when inputs move between edges.
        step(7'h41, 3'd3, 3'd0, 1'b1, "hold_setup");
        character = 7'h20;
        x = 3'd0;
        #3;
        check("hold_between_edges", 1'b1);

        for (int i = 0; i < 64; i++) step(7'h20, 3'(i % 8), 3'(i / 8), 1'b1, "space");

        step(7'h01, 3'd1, 3'd0, 1'b1, "ctrl01_x1y0");
        step(7'h01, 3'd3, 3'd3, 1'b1, "ctrl01_x3y3");
        step(7'h7F, 3'd6, 3'd2, 1'b1, "ctrl7F_x6y2");
        step(7'h1F, 3'd2, 3'd6, 1'b1, "ctrl1F_x2y6");
        step(7'h00, 3'd0, 3'd0, 1'b1, "ctrl00_x0y0");

        for (int i = 0; i < 8; i++)
            step((i % 2 == 0) ? 7'h41 : 7'h20, 3'd3, 3'd0, 1'b1, "alternate");

        for (int c = 8'h21; c <= 8'h7E; c++) begin
            for (int k = 0; k < 8; k++) begin
                step(7'(c), 3'd7, 3'(k), 1'b1, "blank_col7");
                step(7'(c), 3'(k), 3'd7, 1'b1, "blank_row7");
            end
        end

        for (int i = 0; i < 3000; i++) begin
            step(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 15) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
